sr_flag_arbiter: RTL and testbench

Round-robin controller sharing a bank of SR flip-flop flags between several requesters. Each requester asks to set, clear, toggle or no-op one flag. The block grants one request at a time and drives a single-cycle S or R strobe into the flag bank. It reads the flag back to confirm the result and returns an ack/err pulse. It sits between software- or FSM-side command sources and the flag bank, and it guarantees that the bank never sees S=R=1.

---
 rtl/sr_flag_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_sr_flag_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter
// Round-robin arbiter that shares a bank of SR flags between several
// requesters. One request is granted at a time. The block drives a single-cycle
// S or R strobe, reads the flag back, and returns a one-cycle ack with an err bit.
//
// Handshake: a requester raises req[i] with cmd_op/cmd_idx stable and holds it
// until ack[i] pulses. It drops req[i] in the cycle after ack. A req that is
// still high when the block returns to IDLE is taken as a new command. A req
// dropped early is ignored, and the granted transaction still completes.
//
// dbg_state exposes the FSM state (0 IDLE, 1 DRIVE, 2 CHECK, 3 RESP).
module sr_flag_arbiter #(
    parameter int N_REQ   = 4,
    parameter int N_FLAGS = 8,
    localparam int IDX_W  = (N_FLAGS > 1) ? $clog2(N_FLAGS) : 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     cmd_op,
    input  logic [IDX_W*N_REQ-1:0] cmd_idx,
    input  logic [N_FLAGS-1:0]     q_in,
    output logic [N_FLAGS-1:0]     s_out,
    output logic [N_FLAGS-1:0]     r_out,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic                   err,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_win;
    logic [IDX_W-1:0]   r_idx;
    logic               r_exp;
    logic               r_oor;
    logic [N_FLAGS-1:0] r_s;
    logic [N_FLAGS-1:0] r_r;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_ack;
    logic               r_err;
    logic               r_busy;

    // Arbitration results
    logic               w_found;
    logic [PTR_W-1:0]   w_win;
    logic [1:0]         w_op;
    logic [IDX_W-1:0]   w_idx;
    logic [N_REQ-1:0]   w_gnt_vec;
    int                 w_j;

    // Decode of the winning command
    logic               w_oor;
    logic               w_q_sel;
    logic               w_exp;
    logic [N_FLAGS-1:0] w_s_vec;
    logic [N_FLAGS-1:0] w_r_vec;

    // Readback of the granted flag during CHECK
    logic               w_q_chk;
    logic               w_err_next;
    logic [PTR_W-1:0]   w_next_ptr;

    // Round-robin search: start at rr_ptr, wrap, and take the first req that is high
    always_comb begin
        w_found   = 1'b0;
        w_win     = '0;
        w_op      = 2'b00;
        w_idx     = '0;
        w_gnt_vec = '0;
        w_j       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j = int'(r_rr_ptr) + k;
            if (w_j >= N_REQ) begin
                w_j = w_j - N_REQ;
            end
            if (!w_found && req[w_j]) begin
                w_found = 1'b1;
                w_win   = PTR_W'(w_j);
                w_op    = cmd_op[2*w_j +: 2];
                w_idx   = cmd_idx[IDX_W*w_j +: IDX_W];
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (w_found && (int'(w_win) == k)) begin
                w_gnt_vec[k] = 1'b1;
            end
        end
    end

    // Decode the winner's command: expected value and strobe, both sampled this cycle.
    // An out-of-range index reads as 0 and produces no strobe.
    always_comb begin
        w_oor   = (int'(w_idx) >= N_FLAGS);
        w_q_sel = 1'b0;
        w_s_vec = '0;
        w_r_vec = '0;
        for (int i = 0; i < N_FLAGS; i++) begin
            if (int'(w_idx) == i) begin
                w_q_sel = q_in[i];
            end
        end
        case (w_op)
            2'b10:   w_exp = 1'b1;
            2'b01:   w_exp = 1'b0;
            2'b11:   w_exp = ~w_q_sel;
            default: w_exp = w_q_sel;
        endcase
        for (int i = 0; i < N_FLAGS; i++) begin
            if (!w_oor && (int'(w_idx) == i)) begin
                case (w_op)
                    2'b10:   w_s_vec[i] = 1'b1;
                    2'b01:   w_r_vec[i] = 1'b1;
                    2'b11: begin
                        w_s_vec[i] = ~w_q_sel;
                        w_r_vec[i] = w_q_sel;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Readback compare of the latched flag, and the pointer advance past the winner
    always_comb begin
        w_q_chk = 1'b0;
        for (int i = 0; i < N_FLAGS; i++) begin
            if (int'(r_idx) == i) begin
                w_q_chk = q_in[i];
            end
        end
        w_err_next = (w_q_chk != r_exp) | r_oor;
        w_next_ptr = (int'(r_win) + 1 >= N_REQ) ? '0 : r_win + PTR_W'(1);
    end

    // Transaction FSM: IDLE -> DRIVE -> CHECK -> RESP -> IDLE, all outputs registered
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_win    <= '0;
            r_idx    <= '0;
            r_exp    <= 1'b0;
            r_oor    <= 1'b0;
            r_s      <= '0;
            r_r      <= '0;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_DRIVE;
                        r_win   <= w_win;
                        r_idx   <= w_idx;
                        r_exp   <= w_exp;
                        r_oor   <= w_oor;
                        r_s     <= w_s_vec;
                        r_r     <= w_r_vec;
                        r_gnt   <= w_gnt_vec;
                        r_busy  <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    // The bank captures the strobe on this edge, so drop it now
                    r_state <= ST_CHECK;
                    r_s     <= '0;
                    r_r     <= '0;
                end
                ST_CHECK: begin
                    r_state  <= ST_RESP;
                    r_ack    <= r_gnt;
                    r_err    <= w_err_next;
                    r_rr_ptr <= w_next_ptr;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ack   <= '0;
                    r_err   <= 1'b0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s_out     = r_s;
    assign r_out     = r_r;
    assign gnt       = r_gnt;
    assign ack       = r_ack;
    assign err       = r_err;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter. A behavioural SR flag bank is attached to the DUT.
// A table of single commands runs first, followed by hand-written sequences for
// the readback mismatch, the reset during DRIVE, and round-robin fairness.
module tb_sr_flag_arbiter;

  localparam int N_REQ   = 4;
  localparam int N_FLAGS = 6;
  localparam int IDX_W   = 3;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req;
  logic [2*N_REQ-1:0]     cmd_op;
  logic [IDX_W*N_REQ-1:0] cmd_idx;
  logic [N_FLAGS-1:0]     q_in;
  logic [N_FLAGS-1:0]     s_out;
  logic [N_FLAGS-1:0]     r_out;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic                   err;
  logic                   busy;
  logic [1:0]             dbg_state;

  logic [N_FLAGS-1:0]     bank_q;
  logic                   bank_ignore;

  int checks;
  int errors;
  int cyc;
  int last_ack_cyc;
  bit fair_mode;

  // Scoreboard entries are {err, ack_onehot}
  logic [N_REQ:0] exp_q[$];

  typedef struct {
    int         r;
    logic [1:0] op;
    int         idx;
    logic       want_q;
    logic       want_err;
  } vec_t;

  vec_t vecs[12];

  sr_flag_arbiter #(.N_REQ(N_REQ), .N_FLAGS(N_FLAGS)) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .req(req),
    .cmd_op(cmd_op),
    .cmd_idx(cmd_idx),
    .q_in(q_in),
    .s_out(s_out),
    .r_out(r_out),
    .gnt(gnt),
    .ack(ack),
    .err(err),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Flag bank model. bank_ignore makes it ignore strobes, which forces a readback mismatch.
  initial bank_q = '0;
  always @(posedge clk) begin
    if (!bank_ignore) bank_q <= (bank_q & ~r_out) | s_out;
  end
  assign q_in = bank_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [N_REQ-1:0] oh(input int r);
    logic [N_REQ-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  // Monitor: scoreboard pops on ack, ack spacing in fairness mode, strobe invariants
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ack !== '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 64'(ack), 64'(0));
        end else begin
          logic [N_REQ:0] e;
          e = exp_q.pop_front();
          chk("ack", 64'(ack), 64'(e[N_REQ-1:0]));
          chk("err", 64'(err), 64'(e[N_REQ]));
        end
        if (fair_mode && last_ack_cyc >= 0) chk("ack_spacing", 64'(cyc - last_ack_cyc), 64'(4));
        last_ack_cyc = cyc;
      end else begin
        chk("err_idle", 64'(err), 64'(0));
      end
      chk("s_and_r", 64'(s_out & r_out), 64'(0));
      chk("strobe_onehot", 64'($countones(s_out | r_out) <= 1), 64'(1));
    end
  end

  // One command from requester r. The strobe and the final flag are predicted from the bank state.
  task automatic do_cmd(input int r, input logic [1:0] op, input int idx,
                        input logic want_q, input logic want_err);
    logic [N_FLAGS-1:0] es;
    logic [N_FLAGS-1:0] er;
    logic cur;
    bit oor;
    int n;
    oor = (idx >= N_FLAGS);
    cur = oor ? 1'b0 : bank_q[idx];
    es = '0;
    er = '0;
    if (!oor) begin
      case (op)
        2'b10: es[idx] = 1'b1;
        2'b01: er[idx] = 1'b1;
        2'b11: if (cur) er[idx] = 1'b1; else es[idx] = 1'b1;
        default: ;
      endcase
    end
    @(negedge clk);
    cmd_op[2*r +: 2] = op;
    cmd_idx[IDX_W*r +: IDX_W] = idx[IDX_W-1:0];
    req[r] = 1'b1;
    exp_q.push_back({want_err, oh(r)});
    @(negedge clk);
    chk("gnt_drive", 64'(gnt), 64'(oh(r)));
    chk("busy_drive", 64'(busy), 64'(1));
    chk("state_drive", 64'(dbg_state), 64'(1));
    chk("s_out_drive", 64'(s_out), 64'(es));
    chk("r_out_drive", 64'(r_out), 64'(er));
    @(negedge clk);
    chk("s_out_check", 64'(s_out), 64'(0));
    chk("r_out_check", 64'(r_out), 64'(0));
    n = 0;
    while (ack[r] !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (ack[r] !== 1'b1) chk("ack_timeout", 64'(0), 64'(1));
    req[r] = 1'b0;
    @(negedge clk);
    chk("gnt_idle", 64'(gnt), 64'(0));
    chk("busy_idle", 64'(busy), 64'(0));
    if (!oor) chk("flag_q", 64'(bank_q[idx]), 64'(want_q));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int seen;
    checks = 0;
    errors = 0;
    cyc = 0;
    last_ack_cyc = -1;
    fair_mode = 0;
    bank_ignore = 0;
    rst_n = 1'b0;
    req = '0;
    cmd_op = '0;
    cmd_idx = '0;

    vecs[0]  = '{0, 2'b10, 3, 1'b1, 1'b0};
    vecs[1]  = '{1, 2'b01, 3, 1'b0, 1'b0};
    vecs[2]  = '{2, 2'b11, 3, 1'b1, 1'b0};
    vecs[3]  = '{3, 2'b11, 3, 1'b0, 1'b0};
    vecs[4]  = '{0, 2'b00, 3, 1'b0, 1'b0};
    vecs[5]  = '{1, 2'b10, 0, 1'b1, 1'b0};
    vecs[6]  = '{2, 2'b11, 0, 1'b0, 1'b0};
    vecs[7]  = '{3, 2'b11, 5, 1'b1, 1'b0};
    vecs[8]  = '{0, 2'b00, 5, 1'b1, 1'b0};
    vecs[9]  = '{1, 2'b10, 7, 1'b0, 1'b1};
    vecs[10] = '{2, 2'b01, 6, 1'b0, 1'b1};
    vecs[11] = '{3, 2'b11, 7, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_s_out", 64'(s_out), 64'(0));
    chk("rst_r_out", 64'(r_out), 64'(0));
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));

    // Table of single commands
    for (int i = 0; i < 12; i++) begin
      do_cmd(vecs[i].r, vecs[i].op, vecs[i].idx, vecs[i].want_q, vecs[i].want_err);
    end

    // Readback mismatch: the bank ignores the set strobe on idx 1
    bank_ignore = 1;
    do_cmd(1, 2'b10, 1, 1'b0, 1'b1);
    bank_ignore = 0;

    // Reset during DRIVE: the transaction aborts with no ack, and rr_ptr returns to 0
    @(negedge clk);
    cmd_op[2*3 +: 2] = 2'b10;
    cmd_idx[IDX_W*3 +: IDX_W] = 3'd2;
    req[3] = 1'b1;
    @(negedge clk);
    chk("abort_s_before", 64'(s_out), 64'(6'b000100));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_s_out", 64'(s_out), 64'(0));
    chk("abort_r_out", 64'(r_out), 64'(0));
    chk("abort_gnt", 64'(gnt), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    req[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_flag_kept", 64'(bank_q[2]), 64'(0));

    // Fairness: all requesters held, grants rotate from 0 with acks 4 cycles apart
    for (int r = 0; r < N_REQ; r++) begin
      cmd_op[2*r +: 2] = 2'b00;
      cmd_idx[IDX_W*r +: IDX_W] = 3'(r);
    end
    for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, oh(k % N_REQ)});
    fair_mode = 1;
    last_ack_cyc = -1;
    req = '1;
    @(negedge clk);
    chk("fair_first_gnt", 64'(gnt), 64'(oh(0)));
    seen = 0;
    n = 0;
    while (seen < 8 && n < 60) begin
      if (ack !== '0) seen++;
      if (seen < 8) begin
        @(negedge clk);
        n++;
      end
    end
    req = '0;
    if (seen < 8) chk("fair_timeout", 64'(seen), 64'(8));
    repeat (6) @(negedge clk);
    fair_mode = 0;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
